dlsc_serdes_word_align: RTL
===========================

Name: dlsc_serdes_word_align

Overview:
Parametrised word-alignment and lock controller for a source-synchronous LVDS receive lane. It sits behind any ISERDES that delivers SER_BITS bits per clk and drives that ISERDES's bitslip input. It assembles WORD_BITS-wide words, searches for a programmable framing pattern and qualifies lock over a configurable run of good words. It also filters the ISERDES phase-detector outputs for IODELAY tracking. It generalises the fixed 6:1, 12-bit-word, 10-bit-payload sensor deserializer framing logic to arbitrary widths, patterns and thresholds, and adds an explicit lock state machine.

Parameters:
SER_BITS, 6, bits delivered per clk by the ISERDES (2-8)
WORD_BITS, 12, serial word length; must equal SER_BITS*K with K in 1..4
DATA_BITS, 10, payload width extracted from each word
DATA_LSB, 1, bit position of payload LSB within the word
FRAME_MASK, 12'h801, word bits checked for framing
FRAME_VALUE, 12'h001, required value of the masked bits
LOCK_WORDS, 4095, consecutive good words required to declare lock
SLIP_WAIT, 15, clk cycles ignored after each bitslip pulse
PD_BITS, 5, width of the signed phase-detector filter
PD_THRESH, 15, filter magnitude that produces a pd_valid pulse

Ports:
clk  in  1  ISERDES CLKDIV domain clock
rst_n  in  1  reset; synchronous, active-low
in_data  in  SER_BITS  parallel ISERDES output; in_data[SER_BITS-1] is the newest bit
bitslip  out  1  single-cycle pulse to the ISERDES BITSLIP input
in_pd_valid  in  1  ISERDES phase-detector valid
in_pd_inc  in  1  ISERDES phase-detector increment/decrement
pd_clear  in  1  clears the PD filter; assert on IODELAY reset or adjust
lock_mask  in  1  while high and locked, framing errors do not drop lock
out_valid  out  1  high for one cycle per aligned word while locked
out_data  out  DATA_BITS  payload; zero whenever out_valid is low
locked  out  1  lane aligned
lock_error  out  1  one-cycle pulse when lock is lost
slip_count  out  8  saturating count of bitslips since reset
pd_valid  out  1  one-cycle filtered phase-detector request
pd_inc  out  1  direction of the last pd_valid; held between pulses
err_count  out  16  framing errors while locked (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge clk): bitslip=0, out_valid=0, out_data=0, locked=0, lock_error=0, slip_count=0, pd_valid=0, pd_inc=0, err_count=0, FSM=SEARCH, group counter g=0, slip phase s=0, filter=0.
- Assembly: the shift register takes in_data every cycle and keeps the last WORD_BITS bits, newest group in the MSBs. g counts 0..K-1 modulo K. A word completes in a cycle where g==K-1.
- Rollover: each bitslip increments s modulo SER_BITS. When s wraps from SER_BITS-1 to 0, g holds for one cycle instead of advancing. This shifts the word boundary by one group, so every WORD_BITS alignment is reachable. With K=1, g never holds.
- frame_ok = ((word & FRAME_MASK) == FRAME_VALUE), evaluated only on word completion.
- SEARCH: on a completed word, if frame_ok go to VERIFY with good count=1. Otherwise pulse bitslip next cycle and go to SLIP_HOLD.
- SLIP_HOLD: wait SLIP_WAIT cycles (counter from 0), ignore all words, then go to SEARCH.
- VERIFY: good word increments the count; reaching LOCK_WORDS goes to LOCKED with locked=1 in the next cycle. A bad word behaves as in SEARCH (bitslip pulse, then SLIP_HOLD).
- LOCKED, good word: out_valid=1 and out_data=word[DATA_LSB+:DATA_BITS], registered one cycle after completion.
- LOCKED, bad word with lock_mask=1: stay LOCKED; out_valid=0 and out_data=0 for that word.
- LOCKED, bad word with lock_mask=0: locked=0, lock_error pulses for 1 cycle, bitslip pulses, go to SLIP_HOLD.
- slip_count increments on every bitslip pulse and saturates at 255.
- PD filter (every cycle), in priority order:
  - pd_clear: filter=0, pd_valid=0, pd_inc holds.
  - in_pd_valid with in_pd_inc=1: if filter==+PD_THRESH, then pd_valid=1, pd_inc=1, filter=0; else filter+1.
  - in_pd_valid with in_pd_inc=0: if filter==-PD_THRESH, then pd_valid=1, pd_inc=0, filter=0; else filter-1.
  - pd_valid is 0 in all other cycles. Require PD_THRESH < 2^(PD_BITS-1).
- Reset mid-operation discards any partial word and any pending slip hold.
- A parameter violation (WORD_BITS % SER_BITS != 0, K > 4, DATA_LSB+DATA_BITS > WORD_BITS) causes an elaboration error via a generate-time $error.

Optional Feature:
Macro DLSC_WORD_ALIGN_ERRCNT_EN.
- Defined: err_count counts bad words in LOCKED, both masked and unmasked. It saturates at 16'hFFFF, clears on reset, and holds its value when lock is lost.
- Not defined: err_count is tied to 0 and the counter logic is not built.

Test Plan:
- Defaults, stream of 12-bit words 0 + D[9:0] + 1, entered 3 bits late: exactly 3 bitslip pulses, each ≥16 cycles apart; locked rises 4095 good words after the final slip; out_data equals D with 1-cycle latency.
- Defaults, stream shifted by 7 bits: the sixth slip triggers the g hold; total 7 pulses, then lock; slip_count=7.
- Locked, one corrupt word (bit11=1) with lock_mask=1: locked stays 1; that word gives out_valid=0 and out_data=0; err_count=1 with the macro, 0 without.
- Locked, same corrupt word with lock_mask=0: lock_error is a single pulse, locked=0, bitslip pulses, relock occurs after 4095 words.
- 16 consecutive in_pd_valid with in_pd_inc=1: pd_valid pulses once, on the 16th, with pd_inc=1. A pd_clear after 10 increments means no pulse until 16 more increments.
- Assert rst_n=0 for 1 cycle while in VERIFY: all outputs return to reset values next cycle, and a full search restarts.

Source files
------------

// File: rtl/dlsc_serdes_word_align_if.sv
// dlsc_serdes_word_align_if: lane bundle - ISERDES parallel bits and bitslip, aligned payload out.
interface dlsc_serdes_word_align_if #(
    parameter int SER_BITS  = 6,
    parameter int DATA_BITS = 10
);
    logic [SER_BITS-1:0]  in_data;
    logic                 bitslip;
    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    modport master (input in_data, output bitslip, output out_valid, output out_data);
    modport slave (output in_data, input bitslip, input out_valid, input out_data);
endinterface

// File: rtl/dlsc_serdes_word_align.sv
// dlsc_serdes_word_align: ISERDES word alignment, lock qualification and phase-detector filtering.
// Define DLSC_WORD_ALIGN_ERRCNT_EN to build the locked framing-error counter behind err_count.
module dlsc_serdes_word_align #(
    parameter int                   SER_BITS    = 6,
    parameter int                   WORD_BITS   = 12,
    parameter int                   DATA_BITS   = 10,
    parameter int                   DATA_LSB    = 1,
    parameter logic [WORD_BITS-1:0] FRAME_MASK  = 12'h801,
    parameter logic [WORD_BITS-1:0] FRAME_VALUE = 12'h001,
    parameter int                   LOCK_WORDS  = 4095,
    parameter int                   SLIP_WAIT   = 15,
    parameter int                   PD_BITS     = 5,
    parameter int                   PD_THRESH   = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    dlsc_serdes_word_align_if.master       lane,
    input  logic                           in_pd_valid,
    input  logic                           in_pd_inc,
    input  logic                           pd_clear,
    input  logic                           lock_mask,
    output logic                           locked,
    output logic                           lock_error,
    output logic [7:0]                     slip_count,
    output logic                           pd_valid,
    output logic                           pd_inc,
    output logic [15:0]                    err_count
);
    localparam int K    = WORD_BITS / SER_BITS;
    localparam int CMAX = LOCK_WORDS > SLIP_WAIT ? LOCK_WORDS : SLIP_WAIT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = SER_BITS > 1 ? $clog2(SER_BITS) : 1;
    localparam logic signed [PD_BITS-1:0] PD_HI = PD_BITS'(PD_THRESH);
    localparam logic signed [PD_BITS-1:0] PD_LO = -PD_HI;

    typedef enum logic [1:0] {SEARCH, SLIP_HOLD, VERIFY, LOCKED} state_t;

    state_t                     state, state_n;
    logic [CW-1:0]              cnt, cnt_n;
    logic [1:0]                 g;
    logic [SW-1:0]              s;
    logic [WORD_BITS-1:0]       word;
    logic                       word_done, frame_ok, wrap;
    logic                       slip_n, valid_n, lose_n;
    logic signed [PD_BITS-1:0]  pd_acc;

    if (WORD_BITS % SER_BITS != 0 || K < 1 || K > 4 || DATA_LSB + DATA_BITS > WORD_BITS ||
        PD_THRESH >= 2 ** (PD_BITS - 1)) begin : g_bad_params
        $error("dlsc_serdes_word_align: illegal parameter combination");
    end

    if (K == 1) begin : g_one
        assign word = lane.in_data;
    end else begin : g_multi
        logic [WORD_BITS-SER_BITS-1:0] hist;
        always_ff @(posedge clk)
            hist <= rst_n ? word[WORD_BITS-1:SER_BITS] : '0;
        assign word = {lane.in_data, hist};
    end

    assign word_done = g == 2'(K - 1);
    assign frame_ok  = (word & FRAME_MASK) == FRAME_VALUE;
    // The ISERDES rotation returns to its start after SER_BITS slips; holding g moves the boundary one group on.
    assign wrap      = lane.bitslip && s == SW'(SER_BITS - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g <= '0;
            s <= '0;
        end else begin
            if (lane.bitslip)
                s <= wrap ? '0 : s + 1'b1;
            if (!wrap)
                g <= word_done ? '0 : g + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        slip_n  = 1'b0;
        valid_n = 1'b0;
        lose_n  = 1'b0;
        case (state)
            SEARCH, VERIFY: if (word_done) begin
                if (frame_ok) begin
                    cnt_n   = state == SEARCH ? CW'(1) : cnt + 1'b1;
                    state_n = cnt_n == CW'(LOCK_WORDS) ? LOCKED : VERIFY;
                end else begin
                    slip_n  = 1'b1;
                    state_n = SLIP_HOLD;
                    cnt_n   = '0;
                end
            end
            SLIP_HOLD: begin
                cnt_n   = cnt == CW'(SLIP_WAIT - 1) ? '0 : cnt + 1'b1;
                state_n = cnt == CW'(SLIP_WAIT - 1) ? SEARCH : SLIP_HOLD;
            end
            default: if (word_done) begin
                valid_n = frame_ok;
                lose_n  = !frame_ok && !lock_mask;
                slip_n  = lose_n;
                state_n = lose_n ? SLIP_HOLD : LOCKED;
                cnt_n   = lose_n ? '0 : cnt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= SEARCH;
            cnt            <= '0;
            lane.bitslip   <= 1'b0;
            lane.out_valid <= 1'b0;
            lane.out_data  <= '0;
            locked         <= 1'b0;
            lock_error     <= 1'b0;
            slip_count     <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            lane.bitslip   <= slip_n;
            lane.out_valid <= valid_n;
            lane.out_data  <= valid_n ? word[DATA_LSB +: DATA_BITS] : '0;
            locked         <= state_n == LOCKED;
            lock_error     <= lose_n;
            slip_count     <= slip_count + 8'(slip_n && slip_count != 8'hFF);
        end
    end

`ifdef DLSC_WORD_ALIGN_ERRCNT_EN
    logic bad_word;
    assign bad_word = state == LOCKED && word_done && !frame_ok;
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= '0;
        else if (bad_word && err_count != 16'hFFFF)
            err_count <= err_count + 1'b1;
    end
`else
    assign err_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pd_acc   <= '0;
            pd_valid <= 1'b0;
            pd_inc   <= 1'b0;
        end else begin
            pd_valid <= 1'b0;
            if (pd_clear)
                pd_acc <= '0;
            else if (in_pd_valid) begin
                if (pd_acc == (in_pd_inc ? PD_HI : PD_LO)) begin
                    pd_acc   <= '0;
                    pd_valid <= 1'b1;
                    pd_inc   <= in_pd_inc;
                end else
                    pd_acc <= in_pd_inc ? pd_acc + 1'b1 : pd_acc - 1'b1;
            end
        end
    end
endmodule
